// File: rtl/fir_decim_n_pkg.sv
// Shared types and helpers for the multi-channel decimating FIR stage.
package fir_decim_n_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_WRITE
  } state_t;

  localparam int FRAC_BITS_DEFAULT = 10;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One FIR channel: sample history shift register, serial MAC accumulator and
// the registered, scaled result.
module fir_mac_lane
  import fir_decim_n_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int TAPS        = 32,
  parameter int FRAC_BITS   = FRAC_BITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shift_en,
  input  logic                    mac_en,
  input  logic                    clear,
  input  logic                    last,
  input  logic [$clog2(TAPS)-1:0] tap,
  input  logic [COEFF_WIDTH-1:0]  coeff,
  input  logic [DATA_WIDTH-1:0]   sample,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS);

  logic [DATA_WIDTH-1:0]   hist [TAPS];
  logic [DATA_WIDTH-1:0]   tap_sample;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;

  assign tap_sample = hist[tap];

  // Both operands sign-extended to the accumulator width so the product is exact.
  assign prod = $signed({{(ACC_W-DATA_WIDTH){tap_sample[DATA_WIDTH-1]}}, tap_sample})
              * $signed({{(ACC_W-COEFF_WIDTH){coeff[COEFF_WIDTH-1]}}, coeff});

  assign sum = (clear ? '0 : acc) + prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++) hist[k] <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (shift_en) begin
        hist[0] <= sample;
        for (int unsigned k = 1; k < TAPS; k++) hist[k] <= hist[k-1];
      end
      if (mac_en) begin
        acc <= sum;
        // Floor shift, then wrap to the sample width.
        if (last) result <= DATA_WIDTH'(sum >>> FRAC_BITS);
      end
    end
  end

endmodule

// File: rtl/fir_decim_n.sv
// Multi-channel decimating FIR: lockstep FIFO reads, one serial dot product per
// channel every DECIM samples, lockstep FIFO writes.
module fir_decim_n
  import fir_decim_n_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int TAPS        = 32,
  parameter int DECIM       = 8,
  parameter int CHANNELS    = 2,
  parameter int FRAC_BITS   = FRAC_BITS_DEFAULT,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [TAPS] = '{default: '0}
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
  input  logic [CHANNELS-1:0]            in_empty,
  output logic [CHANNELS-1:0]            in_rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] dout,
  input  logic [CHANNELS-1:0]            out_full,
  output logic [CHANNELS-1:0]            out_wr_en
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int CNT_W = cnt_width(DECIM);

  state_t                 state, state_next;
  logic [TAP_W-1:0]       tap_cnt;
  logic [CNT_W-1:0]       sample_cnt;
  logic                   rd, wr, compute, group_done, last_tap;
  logic [COEFF_WIDTH-1:0] coeff;

  // Strobes are shared by all channels so lanes can never slip.
  assign rd         = (state == S_LOAD) && !(|in_empty) && reset;
  assign wr         = (state == S_WRITE) && !(|out_full);
  assign compute    = (state == S_COMPUTE);
  assign group_done = rd && (sample_cnt == CNT_W'(DECIM - 1));
  assign last_tap   = (tap_cnt == TAP_W'(TAPS - 1));
  assign in_rd_en   = {CHANNELS{rd}};
  assign out_wr_en  = {CHANNELS{wr}};
  assign coeff      = COEFFS[tap_cnt];

  always_comb begin
    state_next = state;
    unique case (state)
      S_LOAD:    if (group_done) state_next = S_COMPUTE;
      S_COMPUTE: if (last_tap)   state_next = S_WRITE;
      S_WRITE:   if (wr)         state_next = S_LOAD;
      default:                   state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_LOAD;
      tap_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      state <= state_next;
      if (rd)      sample_cnt <= group_done ? '0 : sample_cnt + 1'b1;
      if (compute) tap_cnt    <= last_tap ? '0 : tap_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    fir_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEFF_WIDTH(COEFF_WIDTH),
      .TAPS       (TAPS),
      .FRAC_BITS  (FRAC_BITS)
    ) u_lane (
      .clk     (clock),
      .rst_n   (reset),
      .shift_en(rd),
      .mac_en  (compute),
      .clear   (tap_cnt == '0),
      .last    (last_tap),
      .tap     (tap_cnt),
      .coeff   (coeff),
      .sample  (x_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .result  (dout[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
